ahb_mem_responder: RTL
======================

# ahb_mem_responder

AHB-Lite responder with internal word memory, programmable wait states and the two-cycle ERROR response. It sits on the same HCLK/HRESET bus as `ahb_master` as a configurable-latency target. It lets the bench exercise master wait-state handling, error handling and write-data parity (HWDATACHK) checking.

## Interface
Parameters:
- ADDR_WIDTH, 20, byte address width
- DATA_WIDTH, 32, data bus width (fixed at 32 for this block)
- MEM_DEPTH, 1024, number of 32-bit words; byte range 0 .. 4*MEM_DEPTH-1
- WAIT_STATES, 1, HREADY-low cycles inserted before each read/write completion (0..15)

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous, active-high reset
- HADDR  in  ADDR_WIDTH  address-phase address
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 half, 2 word; >2 illegal
- HBURST  in  3  burst type (1, 3, 5, 7 = incrementing)
- HWDATA  in  DATA_WIDTH  write data (data phase)
- HWDATACHK  in  4  bit i = XOR of HWDATA[8i+7:8i]
- HRDATA  out  DATA_WIDTH  read data, valid when HREADY=1 and HRSP=0 in a read data phase
- HREADY  out  1  transfer complete / address phase accepted
- HRSP  out  1  0 OKAY, 1 ERROR

## Operation
- **Address-phase sampling:** the address phase is sampled on a rising edge with HREADY=1.
  - NONSEQ and SEQ are active transfers.
  - IDLE and BUSY get a zero-wait OKAY with no memory access.
- **Latched at the address phase:** address, HSIZE, HWRITE, and an error flag.
- **Address-phase error conditions:**
  - word index >= MEM_DEPTH;
  - HSIZE > 2;
  - misalignment: HSIZE=1 with HADDR[0]≠0, or HSIZE=2 with HADDR[1:0]≠0;
  - SEQ with an incrementing HBURST where HADDR ≠ previous active address + 2^HSIZE.
- **States:** IDLE, WAIT, DATA, ERR1, ERR2.
- **IDLE:**
  - active transfer with no error → WAIT if the wait count is > 0, else DATA;
  - active transfer with an error → ERR1.
- **WAIT:**
  - HREADY=0, HRSP=0; an internal counter counts down.
  - Writes sample HWDATA/HWDATACHK on the first WAIT cycle.
  - The wait count for writes is max(WAIT_STATES,1), so write data is always checked before completion.
  - Counter reaches 0 with no parity error → DATA.
  - Parity mismatch on any active byte lane → ERR1.
- **DATA:**
  - HREADY=1, HRSP=0.
  - Reads drive HRDATA with the full addressed word.
  - Writes commit the active byte lanes at the closing edge (little-endian lanes from HSIZE and HADDR[1:0]).
  - A new address phase may be sampled in the same cycle (back-to-back).
- **ERR1:** HREADY=0, HRSP=1 → ERR2.
- **ERR2:**
  - HREADY=1, HRSP=1; no memory write.
  - A new address phase is sampled here as from IDLE; the master normally drives IDLE.
- **Outputs:**
  - HREADY, HRSP and HRDATA are registered.
  - HRDATA = 0 outside read DATA cycles.
- **HBURST:** used only for the SEQ address check. Wrapping bursts (2, 4, 6) and SINGLE are not checked.
- **Memory:** contents are not reset.

## Timing
- **Reset values:** HREADY=1, HRSP=0, HRDATA=0, state IDLE, wait counter 0, previous-address register 0.
- **Read latency:**
  - Data phase = WAIT_STATES HREADY-low cycles + 1 DATA cycle.
  - WAIT_STATES=0 gives a single-cycle data phase.
- **Write data phase:** max(WAIT_STATES,1) + 1 cycles.
- **Error responses:**
  - Address error: exactly 2 cycles (ERR1, ERR2) immediately after the address phase.
  - Parity error: the WAIT cycles elapsed so far, then ERR1, ERR2.
- **Back-to-back:** with WAIT_STATES=0, consecutive read NONSEQ/SEQ transfers complete one per cycle.
- **Reset mid-transfer:**
  - All outputs return to reset values asynchronously.
  - An uncommitted write is dropped; memory is untouched.
- **BUSY inside a burst:** OKAY in 1 cycle. The previous-address register is not updated, so the following SEQ is checked against the last active beat.

## Test plan
- **Write then read, WAIT_STATES=1:** write 0xDEADBEEF to 0x00010 with correct HWDATACHK; read 0x00010 → 1 HREADY-low cycle, then HRDATA=0xDEADBEEF, HRSP=0.
- **Byte write:** HSIZE=0, HADDR=0x00013, HWDATA=0xAB000000, over a word holding 0x11223344 → a subsequent word read returns 0xAB223344.
- **Out-of-range:** read of 0x01000 with MEM_DEPTH=1024 → HREADY=0/HRSP=1, then HREADY=1/HRSP=1; HRDATA=0.
- **Parity error:** word write to 0x00020 with HWDATACHK[2] flipped → 1 wait cycle, then ERR1, ERR2; a read of 0x00020 returns the old value.
- **INCR4 burst, WAIT_STATES=0:** reads from 0x00100 → four consecutive HREADY=1 OKAY cycles. Then drive a SEQ beat at 0x0010C after 0x00104 → error response on that beat.
- **Async reset:** assert HRESET in a write WAIT cycle → HREADY=1, HRSP=0, HRDATA=0 immediately; a later read shows the word unchanged.

Source files
------------

// File: rtl/ahb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_responder
// Desc     : AHB-Lite word-memory target with programmable wait states,
//            write-data parity checking and the two-cycle ERROR response.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 20,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [3:0]            HWDATACHK,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRSP
);

    localparam int unsigned c_mem_aw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned c_idx_w  = ADDR_WIDTH - 2;
    localparam logic [3:0]  c_rd_cnt = 4'(WAIT_STATES);
    // Writes always get at least one wait cycle so the data can be parity-checked
    localparam logic [3:0]  c_wr_cnt = (WAIT_STATES == 0) ? 4'd1 : 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic                    r_first;
    logic                    r_write;
    logic                    w_write_nxt;
    logic [c_mem_aw-1:0]     r_idx;
    logic [3:0]              r_lanes;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [ADDR_WIDTH-1:0]   r_prev_addr;
    logic                    r_hready;
    logic                    r_hrsp;
    logic [DATA_WIDTH-1:0]   r_hrdata;
    logic                    w_hready_nxt;
    logic                    w_hrsp_nxt;
    logic [DATA_WIDTH-1:0]   w_hrdata_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic                    w_take;
    logic                    w_seq_err;
    logic                    w_addr_err;
    logic [3:0]              w_lanes;
    logic [c_idx_w-1:0]      w_word;
    logic [ADDR_WIDTH-1:0]   w_step;
    logic [3:0]              w_par;
    logic                    w_par_err;
    logic                    w_commit;
    logic [c_mem_aw-1:0]     w_rd_idx;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    // ---------------- address-phase decode ----------------
    assign w_take    = r_hready & HTRANS[1];
    assign w_word    = HADDR[ADDR_WIDTH-1:2];
    assign w_step    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << HSIZE;
    assign w_seq_err = (HTRANS == 2'b11) && (HBURST inside {3'd1, 3'd3, 3'd5, 3'd7}) &&
                       (HADDR != r_prev_addr + w_step);
    assign w_addr_err = (32'(w_word) >= MEM_DEPTH) ||
                        (HSIZE > 3'd2) ||
                        ((HSIZE == 3'd1) && HADDR[0]) ||
                        ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00)) ||
                        w_seq_err;

    always_comb begin
        case (HSIZE)
            3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
            3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // ---------------- write-data parity ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_par
            assign w_par[gi] = ^HWDATA[8*gi +: 8];
        end
    endgenerate

    assign w_par_err = |((w_par ^ HWDATACHK) & r_lanes);
    assign w_commit  = (r_state == ST_DATA) && r_write;

    // Read index comes from the bus on a zero-wait read, else from the latch;
    // a write committing on the same edge is forwarded into the read word.
    assign w_rd_idx = (r_state == ST_WAIT) ? r_idx : HADDR[c_mem_aw+1:2];

    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        if (w_commit && (r_idx == w_rd_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (r_lanes[i]) begin
                    w_rd_word[8*i +: 8] = r_wdata[8*i +: 8];
                end
            end
        end
    end

    // ---------------- next state / next outputs ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_write_nxt = r_write;
        case (r_state)
            ST_WAIT: begin
                if (r_first && r_write && w_par_err) begin
                    w_state_nxt = ST_ERR1;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                w_state_nxt = ST_IDLE;
                if (w_take) begin
                    w_write_nxt = HWRITE;
                    if (w_addr_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if ((HWRITE ? c_wr_cnt : c_rd_cnt) != 4'd0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = (HWRITE ? c_wr_cnt : c_rd_cnt) - 4'd1;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
            end
        endcase
        w_hready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DATA) ||
                       (w_state_nxt == ST_ERR2);
        w_hrsp_nxt   = (w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2);
        w_hrdata_nxt = ((w_state_nxt == ST_DATA) && !w_write_nxt) ? w_rd_word : '0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_first     <= 1'b0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_lanes     <= 4'd0;
            r_wdata     <= '0;
            r_prev_addr <= '0;
            r_hready    <= 1'b1;
            r_hrsp      <= 1'b0;
            r_hrdata    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_write  <= w_write_nxt;
            r_first  <= (r_state != ST_WAIT) && (w_state_nxt == ST_WAIT);
            r_hready <= w_hready_nxt;
            r_hrsp   <= w_hrsp_nxt;
            r_hrdata <= w_hrdata_nxt;
            if (w_take) begin
                r_idx       <= HADDR[c_mem_aw+1:2];
                r_lanes     <= w_lanes;
                r_prev_addr <= HADDR;
            end
            if ((r_state == ST_WAIT) && r_first) begin
                r_wdata <= HWDATA;
            end
        end
    end

    // Contents are intentionally not reset; a reset before DATA drops the write.
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_lanes[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign HREADY = r_hready;
    assign HRSP   = r_hrsp;
    assign HRDATA = r_hrdata;

endmodule
`default_nettype wire
